// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-segment table for the multiplexed seven-segment driver.
package seven_seg_pkg;

   localparam int unsigned SEG_W      = 7;
   localparam int unsigned MAX_DIGITS = 8;

   // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
   localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   localparam logic [SEG_W-1:0]      SEG_OFF = '1;
   localparam logic [MAX_DIGITS-1:0] AN_OFF  = '1;

   function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nibble);
      return SEG_LUT[nibble];
   endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational nibble to segment pattern, polarity selected by ACTIVE_LOW.
module hex_to_seven_seg
   import seven_seg_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0]       nibble,
   output logic [SEG_W-1:0] seg_c
);

   assign seg_c = ACTIVE_LOW ? seg_decode(nibble) : ~seg_decode(nibble);

endmodule

// File: rtl/seven_segment_mux_driver.sv
// Time-multiplexed N-digit hex display driver with frame-aligned double buffering
// and an anode blanking guard at the start of every digit slot.
module seven_segment_mux_driver
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned REFRESH_HZ = 1000,
   parameter int unsigned GUARD      = 64,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    load,
   output logic [SEG_W-1:0]        seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start
);

   localparam int unsigned DIV   = CLK_HZ / REFRESH_HZ;
   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic                  DP_IDLE  = ACTIVE_LOW;
   localparam logic [SEG_W-1:0]      SEG_IDLE = ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
   localparam logic [NUM_DIGITS-1:0] AN_IDLE  = ACTIVE_LOW ? AN_OFF[NUM_DIGITS-1:0] : '0;

   if (NUM_DIGITS == 0 || NUM_DIGITS > MAX_DIGITS || DIV < 2 || GUARD >= DIV) begin : g_bad_params
      $error("seven_segment_mux_driver: need 1<=NUM_DIGITS<=8, DIV>=2 and GUARD<DIV");
   end

   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] value;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   en;
   } frame_t;

   frame_t incoming_c;
   frame_t pending;
   frame_t active;

   logic [CNT_W-1:0]      slot_cnt;
   logic [IDX_W-1:0]      digit_idx;
   logic                  slot_last_c;
   logic                  digit_last_c;
   logic                  frame_wrap_c;
   logic                  past_guard_c;
   logic [3:0]            cur_nib_c;
   logic                  cur_dp_c;
   logic [NUM_DIGITS-1:0] an_on_c;
   logic                  any_on_c;
   logic [SEG_W-1:0]      seg_c;

   assign incoming_c   = '{value: value, dp: dp_in, en: digit_en};
   assign slot_last_c  = (slot_cnt == CNT_W'(DIV - 1));
   assign digit_last_c = (digit_idx == IDX_W'(NUM_DIGITS - 1));
   assign frame_wrap_c = slot_last_c && digit_last_c;

   if (GUARD == 0) begin : g_no_guard
      assign past_guard_c = 1'b1;
   end else begin : g_guard
      assign past_guard_c = (slot_cnt >= CNT_W'(GUARD));
   end

   // Slot counter and round-robin digit index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt  <= '0;
         digit_idx <= '0;
      end else begin
         slot_cnt <= slot_last_c ? '0 : slot_cnt + CNT_W'(1);
         if (slot_last_c) begin
            digit_idx <= digit_last_c ? '0 : digit_idx + IDX_W'(1);
         end
      end
   end

   // Pending buffer collects loads; active only changes at a frame boundary, load bypasses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         active  <= '0;
      end else begin
         if (load) begin
            pending <= incoming_c;
         end
         if (frame_wrap_c) begin
            active <= load ? incoming_c : pending;
         end
      end
   end

   always_comb begin
      cur_nib_c = '0;
      cur_dp_c  = 1'b0;
      an_on_c   = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (digit_idx == IDX_W'(k)) begin
            cur_nib_c  = active.value[4*k +: 4];
            cur_dp_c   = active.dp[k];
            an_on_c[k] = past_guard_c && active.en[k];
         end
      end
   end

   assign any_on_c = |an_on_c;

   hex_to_seven_seg #(
      .ACTIVE_LOW (ACTIVE_LOW)
   ) u_hex (
      .nibble (cur_nib_c),
      .seg_c  (seg_c)
   );

   // Registered pin drivers; segments and dp go dark whenever no anode is on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg         <= SEG_IDLE;
         dp          <= DP_IDLE;
         an          <= AN_IDLE;
         frame_start <= 1'b0;
      end else begin
         seg         <= any_on_c ? seg_c : SEG_IDLE;
         dp          <= any_on_c ? (cur_dp_c ^ DP_IDLE) : DP_IDLE;
         an          <= an_on_c ^ AN_IDLE;
         frame_start <= (slot_cnt == '0) && (digit_idx == '0);
      end
   end

endmodule

// File: tb/tb_seven_segment_mux_driver.sv
// Bench for seven_segment_mux_driver: cycle-level display model plus directed literal checks.
module tb_seven_segment_mux_driver;

   localparam int ND    = 4;
   localparam int DIVV  = 10;
   localparam int GRD   = 2;
   localparam int FRAME = ND * DIVV;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   value;
   logic [3:0]    dp_in;
   logic [3:0]    digit_en;
   logic          load;
   logic [6:0]    seg;
   logic          dp;
   logic [3:0]    an;
   logic          frame_start;

   int n_vec = 0;
   int n_err = 0;

   seven_segment_mux_driver #(
      .NUM_DIGITS (ND),
      .CLK_HZ     (1000),
      .REFRESH_HZ (100),
      .GUARD      (GRD),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .dp_in       (dp_in),
      .digit_en    (digit_en),
      .load        (load),
      .seg         (seg),
      .dp          (dp),
      .an          (an),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Display model: m_n counts clock edges since reset; slot and digit follow by arithmetic.
   int          m_n = 0;
   int          m_slot;
   int          m_dig;
   logic        m_on;
   logic [3:0]  m_sel;
   logic [15:0] m_pv = '0, m_av = '0;
   logic [3:0]  m_pd = '0, m_ad = '0, m_pe = '0, m_ae = '0;
   logic [3:0]  exp_an  = 4'hF;
   logic [6:0]  exp_seg = 7'h7F;
   logic        exp_dp  = 1'b1;
   logic        exp_fs  = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n = 0;
         m_pv = '0; m_av = '0; m_pd = '0; m_ad = '0; m_pe = '0; m_ae = '0;
         exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
      end else begin
         m_slot  = m_n % DIVV;
         m_dig   = (m_n / DIVV) % ND;
         m_on    = (m_slot >= GRD) && m_ae[m_dig];
         m_sel   = 4'b0001 << m_dig;
         exp_an  = m_on ? ~m_sel : 4'hF;
         exp_seg = m_on ? hex7(m_av[4*m_dig +: 4]) : 7'h7F;
         exp_dp  = m_on ? ~m_ad[m_dig] : 1'b1;
         exp_fs  = (m_n % FRAME) == 0;
         if (load) begin
            m_pv = value; m_pd = dp_in; m_pe = digit_en;
         end
         if ((m_n % FRAME) == FRAME - 1) begin
            m_av = m_pv; m_ad = m_pd; m_ae = m_pe;
         end
         m_n++;
      end
   end

   always @(negedge clk) begin
      check("an",          32'(an),          32'(exp_an));
      check("seg",         32'(seg),         32'(exp_seg));
      check("dp",          32'(dp),          32'(exp_dp));
      check("frame_start", 32'(frame_start), 32'(exp_fs));
   end

   // Step to the negedge where m_n % FRAME == p; outputs then show state p-1.
   task automatic wait_phase(input int p);
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(negedge clk);
         if ((m_n % FRAME) == p) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL wait_phase %0d: timed out, got m_n %0d required phase %0d", p, m_n, p);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
      value = v; dp_in = d; digit_en = e; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      int cnt;
      int fs_cnt;
      rst_n = 1'b1; load = 1'b0; value = '0; dp_in = '0; digit_en = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp", 32'(dp), 32'h1);
      check("rst_fs", 32'(frame_start), 32'h0);
      #2 rst_n = 1'b1;
      repeat (45) @(negedge clk);
      check("idle_no_load_an", 32'(an), 32'hF);

      // Basic scan
      do_load(16'h3A80, 4'b0100, 4'b1111);
      wait_phase(2);  check("scan_guard_an", 32'(an), 32'hF);
      wait_phase(6);  check("scan_d0_an", 32'(an), 32'hE); check("scan_d0_seg", 32'(seg), 32'b1000000);
      wait_phase(16); check("scan_d1_an", 32'(an), 32'hD); check("scan_d1_seg", 32'(seg), 32'b0000000);
      wait_phase(26); check("scan_d2_an", 32'(an), 32'hB); check("scan_d2_seg", 32'(seg), 32'b0001000);
      check("scan_d2_dp", 32'(dp), 32'h0);
      wait_phase(36); check("scan_d3_an", 32'(an), 32'h7); check("scan_d3_seg", 32'(seg), 32'b0110000);
      check("scan_d3_dp", 32'(dp), 32'h1);
      wait_phase(1);
      cnt = 0; fs_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (an != 4'hF) cnt++;
         if (frame_start) fs_cnt++;
         @(negedge clk);
      end
      check("scan_lit_cycles", 32'(cnt), 32'd32);
      check("frame_start_per_frame", 32'(fs_cnt), 32'd1);

      // Double buffer
      do_load(16'h1111, 4'b0000, 4'b1111);
      wait_phase(1);
      wait_phase(22);
      do_load(16'hFFFF, 4'b0000, 4'b1111);
      wait_phase(26); check("dbuf_d2_old", 32'(seg), 32'b1111001);
      wait_phase(36); check("dbuf_d3_old", 32'(seg), 32'b1111001);
      for (int d = 0; d < ND; d++) begin
         wait_phase(d * DIVV + 6);
         check("dbuf_new", 32'(seg), 32'b0001110);
      end

      // Load on the exact frame boundary edge
      wait_phase(FRAME - 1);
      do_load(16'h2222, 4'b0000, 4'b1111);
      wait_phase(6); check("collide_d0_seg", 32'(seg), 32'b0100100);

      // Blanking with dp requested on disabled digits
      do_load(16'h5555, 4'b1010, 4'b0101);
      wait_phase(1);
      cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (!an[1] || !an[3]) cnt++;
         @(negedge clk);
      end
      check("blank_an13_low", 32'(cnt), 32'd0);
      wait_phase(16); check("blank_d1_an", 32'(an), 32'hF); check("blank_d1_seg", 32'(seg), 32'h7F);
      check("blank_d1_dp", 32'(dp), 32'h1);
      wait_phase(6);  check("blank_d0_an", 32'(an), 32'hE); check("blank_d0_seg", 32'(seg), 32'b0010010);

      // Decode sweep on digit 0
      for (int v = 0; v < 16; v++) begin
         wait_phase(FRAME - 1);
         do_load({12'h000, 4'(v)}, 4'b0000, 4'b0001);
         wait_phase(6);
         check("sweep_seg", 32'(seg), 32'(hex7(4'(v))));
         check("sweep_an", 32'(an), 32'hE);
      end

      // Asynchronous reset mid-slot
      wait_phase(6);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_an", 32'(an), 32'hF);
      check("async_rst_seg", 32'(seg), 32'h7F);
      check("async_rst_dp", 32'(dp), 32'h1);
      check("async_rst_fs", 32'(frame_start), 32'h0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (45) @(negedge clk);
      check("post_rst_dark_an", 32'(an), 32'hF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
